// File: rtl/cellrv32_busswitch_n_if.sv
// Controller-side and peripheral-side signals of the N-port bus switch.
// The switch uses the slave view; controllers and the peripheral model use the master view.
interface cellrv32_busswitch_n_if #(
  parameter int NUM_PORTS = 2,
  parameter int SRC_W     = $clog2(NUM_PORTS)
);
  logic [NUM_PORTS-1:0]    c_bus_priv_i;
  logic [NUM_PORTS-1:0]    c_bus_cached_i;
  logic [NUM_PORTS*32-1:0] c_bus_addr_i;
  logic [NUM_PORTS*32-1:0] c_bus_wdata_i;
  logic [NUM_PORTS*4-1:0]  c_bus_ben_i;
  logic [NUM_PORTS-1:0]    c_bus_we_i;
  logic [NUM_PORTS-1:0]    c_bus_re_i;
  logic [31:0]             c_bus_rdata_o;
  logic [NUM_PORTS-1:0]    c_bus_ack_o;
  logic [NUM_PORTS-1:0]    c_bus_err_o;
  logic                    p_bus_priv_o;
  logic                    p_bus_cached_o;
  logic [SRC_W-1:0]        p_bus_src_o;
  logic [31:0]             p_bus_addr_o;
  logic [31:0]             p_bus_rdata_i;
  logic [31:0]             p_bus_wdata_o;
  logic [3:0]              p_bus_ben_o;
  logic                    p_bus_we_o;
  logic                    p_bus_re_o;
  logic                    p_bus_ack_i;
  logic                    p_bus_err_i;

  modport slave (
    input  c_bus_priv_i, c_bus_cached_i, c_bus_addr_i, c_bus_wdata_i, c_bus_ben_i,
           c_bus_we_i, c_bus_re_i, p_bus_rdata_i, p_bus_ack_i, p_bus_err_i,
    output c_bus_rdata_o, c_bus_ack_o, c_bus_err_o, p_bus_priv_o, p_bus_cached_o,
           p_bus_src_o, p_bus_addr_o, p_bus_wdata_o, p_bus_ben_o, p_bus_we_o, p_bus_re_o
  );

  modport master (
    output c_bus_priv_i, c_bus_cached_i, c_bus_addr_i, c_bus_wdata_i, c_bus_ben_i,
           c_bus_we_i, c_bus_re_i, p_bus_rdata_i, p_bus_ack_i, p_bus_err_i,
    input  c_bus_rdata_o, c_bus_ack_o, c_bus_err_o, p_bus_priv_o, p_bus_cached_o,
           p_bus_src_o, p_bus_addr_o, p_bus_wdata_o, p_bus_ben_o, p_bus_we_o, p_bus_re_o
  );
endinterface

// File: rtl/cellrv32_busswitch_n.sv
// N-port bus switch: NUM_PORTS controllers share one peripheral bus.
// Fixed-priority or round-robin arbitration, per-port strobe buffering while
// the bus is busy, read-only port filtering and an optional bus timeout.
module cellrv32_busswitch_n #(
  parameter int         NUM_PORTS      = 2,
  parameter int         ARB_MODE       = 0,
  parameter logic [7:0] READ_ONLY_MASK = 8'h00,
  parameter int         TIMEOUT        = 0
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  cellrv32_busswitch_n_if.slave bus
);
  localparam int SRC_W = $clog2(NUM_PORTS);

  typedef enum logic [1:0] {IDLE, RETIRE, BUSY} state_t;

  state_t state, state_nxt;

  logic [NUM_PORTS-1:0] ro, re_s, we_s, ro_wr, strobe, cand;
  logic [NUM_PORTS-1:0] rd_buf, wr_buf, ro_err, ack, err;
  logic [SRC_W-1:0]     grant, ptr, win, sel, idx;
  logic                 found, load, fwd_re, fwd_we, tmo;
  logic [7:0]           cnt;

  logic [NUM_PORTS-1:0][31:0] addr, wdata;
  logic [NUM_PORTS-1:0][3:0]  ben;

  assign addr  = bus.c_bus_addr_i;
  assign wdata = bus.c_bus_wdata_i;
  assign ben   = bus.c_bus_ben_i;

  // A write beats a simultaneous read; writes on read-only ports never enter arbitration.
  assign ro     = READ_ONLY_MASK[NUM_PORTS-1:0];
  assign we_s   = bus.c_bus_we_i & ~ro;
  assign ro_wr  = bus.c_bus_we_i & ro;
  assign re_s   = bus.c_bus_re_i & ~bus.c_bus_we_i;
  assign strobe = re_s | we_s;
  assign cand   = strobe | rd_buf | wr_buf;

  // Winner search: from port 0 in fixed mode, from the port after the last grant in round-robin.
  always_comb begin
    win   = '0;
    idx   = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      idx = (ARB_MODE == 0) ? SRC_W'(k) : SRC_W'((int'(ptr) + 1 + k) % NUM_PORTS);
      if (!found && cand[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  // Next state, bus strobes and per-port responses.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    sel       = grant;
    fwd_re    = 1'b0;
    fwd_we    = 1'b0;
    tmo       = 1'b0;
    ack       = '0;
    err       = ro_err;
    unique case (state)
      IDLE: begin
        sel = win;
        if (found) begin
          load = 1'b1;
          if (strobe[win]) begin
            // Fresh strobe goes straight through with no added latency.
            fwd_re    = re_s[win];
            fwd_we    = we_s[win];
            state_nxt = BUSY;
          end else begin
            state_nxt = RETIRE;
          end
        end
      end
      RETIRE: begin
        fwd_re    = rd_buf[grant];
        fwd_we    = wr_buf[grant];
        state_nxt = BUSY;
      end
      BUSY: begin
        tmo = (TIMEOUT != 0) && (cnt == 8'(TIMEOUT - 1)) &&
              !bus.p_bus_ack_i && !bus.p_bus_err_i;
        ack[grant] = bus.p_bus_ack_i;
        err[grant] = ro_err[grant] | bus.p_bus_err_i | tmo;
        if (bus.p_bus_ack_i || bus.p_bus_err_i || tmo) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) state <= IDLE;
    else         state <= state_nxt;
  end

  // Grant, round-robin pointer and busy-cycle counter (cleared outside BUSY).
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      grant <= '0;
      ptr   <= SRC_W'(NUM_PORTS - 1);
      cnt   <= '0;
    end else begin
      if (load) begin
        grant <= win;
        ptr   <= win;
      end
      cnt <= (state == BUSY) ? cnt + 8'd1 : 8'd0;
    end
  end

  // Pending-request buffers and the one-cycle-late read-only write error.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      rd_buf <= '0;
      wr_buf <= '0;
      ro_err <= '0;
    end else begin
      rd_buf <= (rd_buf & ~(ack | err)) | re_s;
      wr_buf <= (wr_buf & ~(ack | err)) | we_s;
      ro_err <= ro_wr;
    end
  end

  assign bus.p_bus_re_o     = fwd_re;
  assign bus.p_bus_we_o     = fwd_we;
  assign bus.p_bus_src_o    = sel;
  assign bus.p_bus_addr_o   = addr[sel];
  assign bus.p_bus_wdata_o  = wdata[sel];
  assign bus.p_bus_ben_o    = ben[sel];
  assign bus.p_bus_priv_o   = bus.c_bus_priv_i[sel];
  assign bus.p_bus_cached_o = bus.c_bus_cached_i[sel];
  assign bus.c_bus_rdata_o  = bus.p_bus_rdata_i;
  assign bus.c_bus_ack_o    = ack;
  assign bus.c_bus_err_o    = err;
endmodule

// File: tb/tb_cellrv32_busswitch_n.sv
// Scoreboard bench for cellrv32_busswitch_n: dut_a is fixed priority with a
// read-only port and timeout, dut_b is round-robin. Expected strobes and
// responses (with their cycle) are queued; negedge monitors pop and compare.
module tb_cellrv32_busswitch_n;
  localparam int N = 4;

  typedef struct {
    int          cyc;
    logic        we;
    logic [1:0]  src;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  ben;
    logic        priv;
    logic        cached;
  } str_t;

  typedef struct {
    int         cyc;
    logic [1:0] port;
    logic       err;
  } rsp_t;

  logic clk = 1'b0;
  logic rstn;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   lat_a, kind_a, lat_b, kind_b;   // kind: 0 ack, 1 err, 2 no response
  int   t;
  logic [3:0] priv_v   = 4'b1010;
  logic [3:0] cached_v = 4'b0110;

  str_t qs_a[$], qs_b[$];
  rsp_t qr_a[$], qr_b[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  cellrv32_busswitch_n_if #(.NUM_PORTS(N)) bus_a ();
  cellrv32_busswitch_n_if #(.NUM_PORTS(N)) bus_b ();

  cellrv32_busswitch_n #(.NUM_PORTS(N), .ARB_MODE(0), .READ_ONLY_MASK(8'h02), .TIMEOUT(8))
    dut_a (.clk_i(clk), .rstn_i(rstn), .bus(bus_a.slave));
  cellrv32_busswitch_n #(.NUM_PORTS(N), .ARB_MODE(1), .READ_ONLY_MASK(8'h00), .TIMEOUT(0))
    dut_b (.clk_i(clk), .rstn_i(rstn), .bus(bus_b.slave));

  function automatic logic [31:0] addr_of(input int d, input int p);
    if (d == 1) return 32'h1000_0000 + 32'(p * 16);
    if (p == 1) return 32'h0000_1000;
    return 32'h2000_0000 + 32'(p * 4);
  endfunction

  function automatic logic [31:0] wdata_of(input int d, input int p);
    if (d == 0 && p == 0) return 32'hDEAD_BEEF;
    return 32'hA500_0000 | 32'(d * 256 + p);
  endfunction

  function automatic logic [3:0] ben_of(input int p);
    return (p == 0) ? 4'hF : 4'h3;
  endfunction

  function automatic str_t mk_s(input int d, input int c, input int p, input logic we);
    str_t e;
    e.cyc = c; e.we = we; e.src = 2'(p);
    e.addr = addr_of(d, p); e.wdata = wdata_of(d, p); e.ben = ben_of(p);
    e.priv = priv_v[p]; e.cached = cached_v[p];
    return e;
  endfunction

  function automatic rsp_t mk_r(input int c, input int p, input logic err);
    rsp_t r;
    r.cyc = c; r.port = 2'(p); r.err = err;
    return r;
  endfunction

  function automatic int head_s(input int d);
    if (d == 0) return (qs_a.size() > 0) ? qs_a[0].cyc : 1 << 30;
    return (qs_b.size() > 0) ? qs_b[0].cyc : 1 << 30;
  endfunction

  function automatic int head_r(input int d);
    if (d == 0) return (qr_a.size() > 0) ? qr_a[0].cyc : 1 << 30;
    return (qr_b.size() > 0) ? qr_b[0].cyc : 1 << 30;
  endfunction

  function automatic bit pop_s(input int d, output str_t e);
    e = mk_s(d, -1, 0, 1'b0);
    if (d == 0) begin
      if (qs_a.size() == 0) return 1'b0;
      e = qs_a.pop_front();
    end else begin
      if (qs_b.size() == 0) return 1'b0;
      e = qs_b.pop_front();
    end
    return 1'b1;
  endfunction

  function automatic bit pop_r(input int d, output rsp_t r);
    r = mk_r(-1, 0, 1'b0);
    if (d == 0) begin
      if (qr_a.size() == 0) return 1'b0;
      r = qr_a.pop_front();
    end else begin
      if (qr_b.size() == 0) return 1'b0;
      r = qr_b.pop_front();
    end
    return 1'b1;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Compare whatever the DUT presents this cycle against the queued expectations.
  task automatic mon(input int d);
    logic re, we, priv, cached;
    logic [1:0] src;
    logic [31:0] addr, wdata;
    logic [3:0] ben, ack, err;
    int kind;
    str_t e;
    rsp_t r;
    if (d == 0) begin
      re = bus_a.p_bus_re_o; we = bus_a.p_bus_we_o; src = bus_a.p_bus_src_o;
      addr = bus_a.p_bus_addr_o; wdata = bus_a.p_bus_wdata_o; ben = bus_a.p_bus_ben_o;
      priv = bus_a.p_bus_priv_o; cached = bus_a.p_bus_cached_o;
      ack = bus_a.c_bus_ack_o; err = bus_a.c_bus_err_o;
    end else begin
      re = bus_b.p_bus_re_o; we = bus_b.p_bus_we_o; src = bus_b.p_bus_src_o;
      addr = bus_b.p_bus_addr_o; wdata = bus_b.p_bus_wdata_o; ben = bus_b.p_bus_ben_o;
      priv = bus_b.p_bus_priv_o; cached = bus_b.p_bus_cached_o;
      ack = bus_b.c_bus_ack_o; err = bus_b.c_bus_err_o;
    end
    while (head_s(d) < cyc) begin
      void'(pop_s(d, e));
      checks++; errors++;
      $display("FAIL strobe_d%0d: no strobe seen, expected src=%0d at cyc %0d (now %0d)", d, e.src, e.cyc, cyc);
    end
    while (head_r(d) < cyc) begin
      void'(pop_r(d, r));
      checks++; errors++;
      $display("FAIL resp_d%0d: no response seen, expected port=%0d err=%0b at cyc %0d (now %0d)", d, r.port, r.err, r.cyc, cyc);
    end
    if (re || we) begin
      checks++;
      if (!pop_s(d, e)) begin
        errors++;
        $display("FAIL strobe_d%0d: got src=%0d re=%0b we=%0b at cyc %0d, expected no strobe", d, src, re, we, cyc);
      end else if (e.cyc != cyc || e.we !== we || re === we || e.src !== src || e.addr !== addr ||
                   e.priv !== priv || e.cached !== cached || (we && (e.wdata !== wdata || e.ben !== ben))) begin
        errors++;
        $display("FAIL strobe_d%0d: got cyc=%0d src=%0d re=%0b we=%0b addr=%h wdata=%h ben=%h priv=%0b cached=%0b, expected cyc=%0d src=%0d we=%0b addr=%h wdata=%h ben=%h priv=%0b cached=%0b",
                 d, cyc, src, re, we, addr, wdata, ben, priv, cached,
                 e.cyc, e.src, e.we, e.addr, e.wdata, e.ben, e.priv, e.cached);
      end
    end
    for (int p = 0; p < N; p++) begin
      if (ack[p] || err[p]) begin
        checks++;
        kind = (ack[p] && err[p]) ? 2 : (err[p] ? 1 : 0);
        if (!pop_r(d, r)) begin
          errors++;
          $display("FAIL resp_d%0d: got port=%0d ack=%0b err=%0b at cyc %0d, expected no response", d, p, ack[p], err[p], cyc);
        end else if (r.cyc != cyc || int'(r.port) != p || kind != int'(r.err)) begin
          errors++;
          $display("FAIL resp_d%0d: got cyc=%0d port=%0d ack=%0b err=%0b, expected cyc=%0d port=%0d err=%0b",
                   d, cyc, p, ack[p], err[p], r.cyc, r.port, r.err);
        end
      end
    end
  endtask

  always @(negedge clk) begin
    mon(0);
    mon(1);
  end

  // Peripheral model for dut_a: answers each strobe after lat_a cycles.
  initial begin
    bus_a.p_bus_ack_i = 1'b0;
    bus_a.p_bus_err_i = 1'b0;
    forever begin
      @(negedge clk);
      if (rstn && (bus_a.p_bus_re_o || bus_a.p_bus_we_o) && kind_a != 2) begin
        repeat (lat_a) @(posedge clk);
        #1;
        if (kind_a == 0) bus_a.p_bus_ack_i = 1'b1;
        else             bus_a.p_bus_err_i = 1'b1;
        @(posedge clk);
        #1;
        bus_a.p_bus_ack_i = 1'b0;
        bus_a.p_bus_err_i = 1'b0;
      end
    end
  end

  // Peripheral model for dut_b.
  initial begin
    bus_b.p_bus_ack_i = 1'b0;
    bus_b.p_bus_err_i = 1'b0;
    forever begin
      @(negedge clk);
      if (rstn && (bus_b.p_bus_re_o || bus_b.p_bus_we_o) && kind_b != 2) begin
        repeat (lat_b) @(posedge clk);
        #1;
        if (kind_b == 0) bus_b.p_bus_ack_i = 1'b1;
        else             bus_b.p_bus_err_i = 1'b1;
        @(posedge clk);
        #1;
        bus_b.p_bus_ack_i = 1'b0;
        bus_b.p_bus_err_i = 1'b0;
      end
    end
  end

  initial begin
    rstn = 1'b0;
    kind_a = 0; lat_a = 1; kind_b = 0; lat_b = 1;
    bus_a.c_bus_priv_i = priv_v;   bus_b.c_bus_priv_i = priv_v;
    bus_a.c_bus_cached_i = cached_v; bus_b.c_bus_cached_i = cached_v;
    bus_a.c_bus_re_i = '0; bus_a.c_bus_we_i = '0;
    bus_b.c_bus_re_i = '0; bus_b.c_bus_we_i = '0;
    bus_a.p_bus_rdata_i = 32'hCAFE_0001;
    bus_b.p_bus_rdata_i = 32'hCAFE_0002;
    for (int p = 0; p < N; p++) begin
      bus_a.c_bus_addr_i[32*p +: 32]  = addr_of(0, p);
      bus_b.c_bus_addr_i[32*p +: 32]  = addr_of(1, p);
      bus_a.c_bus_wdata_i[32*p +: 32] = wdata_of(0, p);
      bus_b.c_bus_wdata_i[32*p +: 32] = wdata_of(1, p);
      bus_a.c_bus_ben_i[4*p +: 4]     = ben_of(p);
      bus_b.c_bus_ben_i[4*p +: 4]     = ben_of(p);
    end
    tick(3);

    // Reset state: quiet outputs, mux on port 0, read data passes through.
    chk("rst_a_quiet", 64'({bus_a.p_bus_re_o, bus_a.p_bus_we_o, bus_a.c_bus_ack_o, bus_a.c_bus_err_o}), 64'h0);
    chk("rst_b_quiet", 64'({bus_b.p_bus_re_o, bus_b.p_bus_we_o, bus_b.c_bus_ack_o, bus_b.c_bus_err_o}), 64'h0);
    chk("rst_a_src", 64'(bus_a.p_bus_src_o), 64'h0);
    chk("rst_a_addr", 64'(bus_a.p_bus_addr_o), 64'(addr_of(0, 0)));
    chk("rdata_a", 64'(bus_a.c_bus_rdata_o), 64'h0000_0000_CAFE_0001);
    chk("rdata_b", 64'(bus_b.c_bus_rdata_o), 64'h0000_0000_CAFE_0002);
    rstn = 1'b1;
    tick(2);

    // Fixed priority: ports 1 and 3 together; 1 goes now, 3 retires after the ack.
    lat_a = 2; kind_a = 0; t = cyc;
    qs_a.push_back(mk_s(0, t, 1, 1'b0));
    qr_a.push_back(mk_r(t + 2, 1, 1'b0));
    qs_a.push_back(mk_s(0, t + 4, 3, 1'b0));
    qr_a.push_back(mk_r(t + 6, 3, 1'b0));
    bus_a.c_bus_re_i = 4'b1010;
    tick(1); bus_a.c_bus_re_i = '0;
    tick(10);

    // Write on read-only port 1: never forwarded, error one cycle later.
    lat_a = 1; t = cyc;
    qr_a.push_back(mk_r(t + 1, 1, 1'b1));
    bus_a.c_bus_we_i = 4'b0010;
    tick(1); bus_a.c_bus_we_i = '0;
    tick(5);

    // Port 0 write answered by a bus error; buffer must not replay it.
    kind_a = 1; lat_a = 1; t = cyc;
    qs_a.push_back(mk_s(0, t, 0, 1'b1));
    qr_a.push_back(mk_r(t + 1, 0, 1'b1));
    bus_a.c_bus_we_i = 4'b0001;
    tick(1); bus_a.c_bus_we_i = '0;
    tick(6);

    // Timeout: error on the 8th busy cycle, the late ack two cycles on is dropped.
    kind_a = 0; lat_a = 10; t = cyc;
    qs_a.push_back(mk_s(0, t, 2, 1'b0));
    qr_a.push_back(mk_r(t + 8, 2, 1'b1));
    bus_a.c_bus_re_i = 4'b0100;
    tick(1); bus_a.c_bus_re_i = '0;
    tick(15);

    // Reset while busy on port 3 with port 2 buffered.
    kind_a = 2; t = cyc;
    qs_a.push_back(mk_s(0, t, 3, 1'b0));
    bus_a.c_bus_re_i = 4'b1000;
    tick(1); bus_a.c_bus_re_i = 4'b0100;
    tick(1); bus_a.c_bus_re_i = '0;
    rstn = 1'b0;
    #1;
    chk("midrst_quiet", 64'({bus_a.p_bus_re_o, bus_a.p_bus_we_o, bus_a.c_bus_ack_o, bus_a.c_bus_err_o}), 64'h0);
    chk("midrst_src", 64'(bus_a.p_bus_src_o), 64'h0);
    tick(1); rstn = 1'b1;
    tick(6);
    kind_a = 0; lat_a = 1; t = cyc;
    qs_a.push_back(mk_s(0, t, 1, 1'b0));
    qr_a.push_back(mk_r(t + 1, 1, 1'b0));
    bus_a.c_bus_re_i = 4'b0010;
    tick(1); bus_a.c_bus_re_i = '0;
    tick(4);

    // Round-robin: all four request, 0 and 1 re-request after their acks.
    lat_b = 1; kind_b = 0; t = cyc;
    qs_b.push_back(mk_s(1, t,      0, 1'b0)); qr_b.push_back(mk_r(t + 1,  0, 1'b0));
    qs_b.push_back(mk_s(1, t + 3,  1, 1'b0)); qr_b.push_back(mk_r(t + 4,  1, 1'b0));
    qs_b.push_back(mk_s(1, t + 6,  2, 1'b0)); qr_b.push_back(mk_r(t + 7,  2, 1'b0));
    qs_b.push_back(mk_s(1, t + 9,  3, 1'b0)); qr_b.push_back(mk_r(t + 10, 3, 1'b0));
    qs_b.push_back(mk_s(1, t + 12, 0, 1'b0)); qr_b.push_back(mk_r(t + 13, 0, 1'b0));
    qs_b.push_back(mk_s(1, t + 15, 1, 1'b0)); qr_b.push_back(mk_r(t + 16, 1, 1'b0));
    bus_b.c_bus_re_i = 4'b1111;
    tick(1); bus_b.c_bus_re_i = '0;
    tick(1); bus_b.c_bus_re_i = 4'b0001;
    tick(1); bus_b.c_bus_re_i = '0;
    tick(2); bus_b.c_bus_re_i = 4'b0010;
    tick(1); bus_b.c_bus_re_i = '0;
    tick(16);

    chk("drain_qs_a", 64'(qs_a.size()), 64'h0);
    chk("drain_qr_a", 64'(qr_a.size()), 64'h0);
    chk("drain_qs_b", 64'(qs_b.size()), 64'h0);
    chk("drain_qr_b", 64'(qr_b.size()), 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/cellrv32_busswitch_n.md
Name: cellrv32_busswitch_n

Overview:
N-port successor of the two-port bus switch. It lets NUM_PORTS controller ports share one peripheral bus. Arbitration is selectable: fixed priority or round-robin. Strobes that arrive while the bus is busy are buffered per port, and an optional bus-timeout returns an error to the stalled controller. It sits between the CPU fetch/data ports, DMA and debug controllers and the processor-internal bus.

Parameters:
NUM_PORTS, 2, number of controller ports (2..8).
ARB_MODE, 0, 0 = fixed priority (port 0 highest); 1 = round-robin.
READ_ONLY_MASK, 0, bit i set = port i is read-only.
TIMEOUT, 0, bus-busy cycles before abort with error (0 = disabled; else 2..255).
SRC_W, $clog2(NUM_PORTS), width of p_bus_src_o (derived).

Ports:
clk_i  in  1  global clock, rising edge
rstn_i  in  1  global reset, low-active, async
c_bus_priv_i  in  NUM_PORTS  per-port privilege level
c_bus_cached_i  in  NUM_PORTS  per-port cached-transfer flag
c_bus_addr_i  in  NUM_PORTS*32  per-port address (port i at bits 32i+31:32i)
c_bus_wdata_i  in  NUM_PORTS*32  per-port write data
c_bus_ben_i  in  NUM_PORTS*4  per-port byte enables
c_bus_we_i  in  NUM_PORTS  per-port write strobe (single cycle)
c_bus_re_i  in  NUM_PORTS  per-port read strobe (single cycle)
c_bus_rdata_o  out  32  read data, broadcast to all ports (= p_bus_rdata_i)
c_bus_ack_o  out  NUM_PORTS  per-port acknowledge
c_bus_err_o  out  NUM_PORTS  per-port error
p_bus_priv_o  out  1  privilege of granted port
p_bus_cached_o  out  1  cached flag of granted port
p_bus_src_o  out  SRC_W  index of granted port
p_bus_addr_o  out  32  address of granted port
p_bus_rdata_i  in  32  peripheral read data
p_bus_wdata_o  out  32  write data of granted port
p_bus_ben_o  out  4  byte enables of granted port
p_bus_we_o  out  1  write strobe
p_bus_re_o  out  1  read strobe
p_bus_ack_i  in  1  peripheral acknowledge
p_bus_err_i  in  1  peripheral error

Behaviour:
- Clock and reset: one clock, clk_i. Reset rstn_i is asynchronous, active-low.
- Reset state: state=IDLE, all request buffers 0, grant register 0, rr pointer NUM_PORTS-1 (port 0 wins first), timeout counter 0. All strobes, ack and err outputs are 0. Mux outputs show port 0.
- Request buffers: per port, rd_buf[i] and wr_buf[i] set on the port's strobe and clear on c_bus_ack_o[i] or c_bus_err_o[i].
  - wr_buf is never set on read-only ports.
  - If re and we arrive together on one port, we wins and re is dropped.
- Read-only write: a we strobe on a port whose READ_ONLY_MASK bit is set is not forwarded. It produces c_bus_err_o[i]=1 exactly one cycle later and occupies no arbitration slot.
- Candidates for a port: a current strobe or a pending buffer.
  - Fixed mode: lowest index wins.
  - Round-robin mode: search starts at ptr+1 modulo NUM_PORTS. ptr updates to the winner on every grant.
- State IDLE: mux select = winner (combinational).
  - If the winner has a current strobe: forward it on p_bus_re_o/we_o in the same cycle (zero latency), register grant=winner, go to BUSY.
  - Else, if the winner has only a pending buffer: register grant, go to RETIRE.
  - No candidate: stay in IDLE; strobes stay 0.
- State RETIRE: select=grant. Drive p_bus_we_o=wr_buf[grant] and p_bus_re_o=rd_buf[grant] for exactly one cycle, then go to BUSY.
- State BUSY: select=grant, p_bus strobes held 0.
  - Ack and err route only to grant; ack/err arriving in any other state are ignored.
  - On p_bus_ack_i or p_bus_err_i: pulse the matching c_bus_ack_o/err_o[grant] in the same cycle, go to IDLE. The next grant happens in the following cycle.
- Timeout (TIMEOUT>0): the counter clears on entering BUSY and increments every BUSY cycle. When it reaches TIMEOUT-1 with no ack/err, pulse c_bus_err_o[grant] and go to IDLE. A late p_bus_ack_i after that is discarded.
- Other ports during BUSY/RETIRE: their strobes are buffered only, never forwarded and never lost.
- Reset mid-transfer: everything clears asynchronously; no ack or err is issued for the aborted access.
- Controllers must not issue a new strobe before the response to their previous one.

Test Plan:
- N=4, ARB_MODE=0: ports 1 and 3 strobe re in the same cycle → port 1 forwarded in that cycle (src=1). Ack after 2 cycles → ack_o[1]. Port 3 then goes through RETIRE: p_bus_re_o high 2 cycles after the ack, src=3.
- N=4, ARB_MODE=1: all ports hold continuous re requests, ack after 1 cycle → grants rotate 0,1,2,3,0; no port starves.
- Write from READ_ONLY_MASK=4'b0010 port 1, addr 0x0000_1000 → p_bus_we_o stays 0; err_o[1]=1 one cycle later.
- TIMEOUT=8, no ack → err_o[grant] pulses on the 8th BUSY cycle. A late ack 2 cycles later → no c_bus_ack_o pulse.
- Port 0 we (wdata 0xDEADBEEF, ben 4'hF) accepted, then p_bus_err_i → err_o[0]=1, ack_o=0, wr_buf[0] cleared.
- rstn_i low during BUSY → all outputs 0 immediately. After release, the previously buffered strobe is gone and the FSM is in IDLE.
